// File: rtl/pulse_seq_pkg.sv
// Shared widths, state encoding and period/width helpers for the pulse sequencer.
package pulse_seq_pkg;

    localparam int W_TIMP  = 10;
    localparam int W_TPER  = 13;
    localparam int W_NIMP  = 6;
    localparam int N_PER   = 32;
    localparam int W_TABLE = W_TPER * N_PER;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Entry k of the packed table; a zero entry still times one unit.
    function automatic logic [W_TPER-1:0] eff_period(input logic [W_TABLE-1:0] tbl,
                                                      input logic [4:0]         k);
        logic [W_TPER-1:0] entry;
        entry = tbl[W_TPER*int'(k) +: W_TPER];
        return (entry == '0) ? W_TPER'(1) : entry;
    endfunction

    function automatic logic [W_TPER-1:0] eff_width(input logic [W_TIMP-1:0] timp,
                                                     input logic [W_TPER-1:0] period);
        logic [W_TPER-1:0] timp_ext;
        logic [W_TPER-1:0] limit;
        timp_ext = {{(W_TPER-W_TIMP){1'b0}}, timp};
        limit    = period - W_TPER'(1);
        return (timp_ext < limit) ? timp_ext : limit;
    endfunction

endpackage

// File: rtl/pulse_sequencer_unit_ticker.sv
// Prescaler: divides the clock into time units and flags the last cycle of each unit.
module unit_ticker #(
    parameter int CLK_PER_UNIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_PER_UNIT - 1);

    logic [7:0] ucnt;

    assign tick = en && (ucnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt <= '0;
        end else if (clear || tick) begin
            ucnt <= '0;
        end else if (en) begin
            ucnt <= ucnt + 8'd1;
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Burst pulse sequencer: latches one burst's parameters on a start edge and times
// NUM_OF_IMP gated pulses with per-pulse phase-reset strobes for the DDS.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CLK_PER_UNIT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SIGN_START_GEN,
    input  logic               STOP,
    input  logic [1:0]         SIGNAL_TYPE,
    input  logic [31:0]        F_CARRIER,
    input  logic [21:0]        DEVIATION,
    input  logic [W_TIMP-1:0]  T_IMPULSE,
    input  logic [W_NIMP-1:0]  NUM_OF_IMP,
    input  logic               VOBULATION,
    input  logic [W_TABLE-1:0] T_PERIODS,
    output logic [1:0]         SIGNAL_TYPE_L,
    output logic [31:0]        F_CARRIER_L,
    output logic [21:0]        DEVIATION_L,
    output logic               IMP_ACTIVE,
    output logic               IMP_START,
    output logic [W_NIMP-1:0]  IMP_INDEX,
    output logic               BUSY,
    output logic               DONE
);

    state_t             state, nxt_state;
    logic               start_d, armed, start_edge, latch_en, tick;
    logic [W_TPER-1:0]  pcnt, nxt_pcnt, cur_p, nxt_p, nxt_w;
    logic [W_NIMP-1:0]  nxt_index, num_q;
    logic [W_TIMP-1:0]  timp_q, src_timp;
    logic [W_TABLE-1:0] table_q, src_table;
    logic               vob_q, src_vob, period_end, new_pulse;

    // armed stays low until start is seen low, so a level held through reset never counts as an edge.
    assign start_edge = SIGN_START_GEN & ~start_d & armed;
    assign latch_en   = (state == IDLE) && start_edge && !STOP;

    unit_ticker #(.CLK_PER_UNIT(CLK_PER_UNIT)) u_ticker (
        .clk   (CLK),
        .rst_n (RESET),
        .clear (state != RUN),
        .en    (state == RUN),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= nxt_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_state  = state;
        nxt_pcnt   = pcnt;
        nxt_index  = IMP_INDEX;
        new_pulse  = 1'b0;
        src_table  = table_q;
        src_vob    = vob_q;
        src_timp   = timp_q;
        cur_p      = eff_period(table_q, vob_q ? IMP_INDEX[4:0] : 5'd0);
        period_end = (state == RUN) && tick && (pcnt == cur_p - W_TPER'(1));

        unique case (state)
            IDLE: begin
                if (latch_en) begin
                    // Outputs are registered, so the first pulse is sized from the incoming parameters.
                    src_table = T_PERIODS;
                    src_vob   = VOBULATION;
                    src_timp  = T_IMPULSE;
                    nxt_index = '0;
                    nxt_pcnt  = '0;
                    if (NUM_OF_IMP == '0) begin
                        nxt_state = FINISH;
                    end else begin
                        nxt_state = RUN;
                        new_pulse = 1'b1;
                    end
                end
            end
            RUN: begin
                if (STOP) begin
                    nxt_state = IDLE;
                    nxt_index = '0;
                    nxt_pcnt  = '0;
                end else if (period_end) begin
                    nxt_pcnt = '0;
                    if (IMP_INDEX == num_q - W_NIMP'(1)) begin
                        nxt_state = FINISH;
                        nxt_index = '0;
                    end else begin
                        nxt_index = IMP_INDEX + W_NIMP'(1);
                        new_pulse = 1'b1;
                    end
                end else if (tick) begin
                    nxt_pcnt = pcnt + W_TPER'(1);
                end
            end
            FINISH:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        nxt_p = eff_period(src_table, src_vob ? nxt_index[4:0] : 5'd0);
        nxt_w = eff_width(src_timp, nxt_p);
    end

    // NOTE: the latched period table is an ordinary flop bank, so it takes the async reset too.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            start_d       <= 1'b0;
            armed         <= 1'b0;
            pcnt          <= '0;
            IMP_INDEX     <= '0;
            num_q         <= '0;
            vob_q         <= 1'b0;
            timp_q        <= '0;
            table_q       <= '0;
            SIGNAL_TYPE_L <= '0;
            F_CARRIER_L   <= '0;
            DEVIATION_L   <= '0;
            IMP_ACTIVE    <= 1'b0;
            IMP_START     <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
        end else begin
            start_d    <= SIGN_START_GEN;
            armed      <= armed | ~SIGN_START_GEN;
            pcnt       <= nxt_pcnt;
            IMP_INDEX  <= nxt_index;
            IMP_ACTIVE <= (nxt_state == RUN) && (nxt_pcnt < nxt_w);
            IMP_START  <= new_pulse;
            BUSY       <= (nxt_state == RUN);
            DONE       <= (nxt_state == FINISH);
            if (latch_en) begin
                num_q         <= NUM_OF_IMP;
                vob_q         <= VOBULATION;
                timp_q        <= T_IMPULSE;
                table_q       <= T_PERIODS;
                SIGNAL_TYPE_L <= SIGNAL_TYPE;
                F_CARRIER_L   <= F_CARRIER;
                DEVIATION_L   <= DEVIATION;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: one CLK_PER_UNIT=1 instance plus a CLK_PER_UNIT=3 instance.
module tb_pulse_sequencer;
    import pulse_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, start, stop, vob;
    logic [1:0]   sig_type;
    logic [31:0]  f_carrier;
    logic [21:0]  deviation;
    logic [9:0]   t_imp;
    logic [5:0]   num;
    logic [415:0] periods;

    logic [1:0]  sig_l, sig_l3;
    logic [31:0] f_l, f_l3;
    logic [21:0] dev_l, dev_l3;
    logic        active, pstart, busy, done, active3, pstart3, busy3, done3;
    logic [5:0]  index, index3;
    logic [9:0]  o1, o3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign o1 = {busy, active, pstart, done, index};
    assign o3 = {busy3, active3, pstart3, done3, index3};

    pulse_sequencer #(.CLK_PER_UNIT(1)) dut (
        .CLK(clk), .RESET(rst_n), .SIGN_START_GEN(start), .STOP(stop),
        .SIGNAL_TYPE(sig_type), .F_CARRIER(f_carrier), .DEVIATION(deviation),
        .T_IMPULSE(t_imp), .NUM_OF_IMP(num), .VOBULATION(vob), .T_PERIODS(periods),
        .SIGNAL_TYPE_L(sig_l), .F_CARRIER_L(f_l), .DEVIATION_L(dev_l),
        .IMP_ACTIVE(active), .IMP_START(pstart), .IMP_INDEX(index), .BUSY(busy), .DONE(done)
    );

    pulse_sequencer #(.CLK_PER_UNIT(3)) dut3 (
        .CLK(clk), .RESET(rst_n), .SIGN_START_GEN(start), .STOP(stop),
        .SIGNAL_TYPE(sig_type), .F_CARRIER(f_carrier), .DEVIATION(deviation),
        .T_IMPULSE(t_imp), .NUM_OF_IMP(num), .VOBULATION(vob), .T_PERIODS(periods),
        .SIGNAL_TYPE_L(sig_l3), .F_CARRIER_L(f_l3), .DEVIATION_L(dev_l3),
        .IMP_ACTIVE(active3), .IMP_START(pstart3), .IMP_INDEX(index3), .BUSY(busy3), .DONE(done3)
    );

    // Expected {BUSY, IMP_ACTIVE, IMP_START, DONE, IMP_INDEX} in cycle c of a fixed-period burst
    // of n pulses, effective period p (in clocks) and effective gate width w (in clocks).
    function automatic logic [9:0] model(int c, int n, int p, int w);
        int ph;
        if (n > 0 && c >= 1 && c <= n * p) begin
            ph = (c - 1) % p;
            return {1'b1, ph < w, ph == 0, 1'b0, 6'((c - 1) / p)};
        end
        if (c == n * p + 1) return {4'b0001, 6'd0};
        return '0;
    endfunction

    task automatic idle_gap();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_entry0(input logic [12:0] v);
        periods       = '0;
        periods[12:0] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; vob = 1'b0;
        sig_type = 2'b11; f_carrier = 32'hFFFF_0000; deviation = 22'h3FFFFF;
        t_imp = 10'd2; num = 6'd3; set_entry0(13'd5);
        repeat (2) @(negedge clk);
        checks++;
        if (o1 !== 10'd0 || o3 !== 10'd0) begin
            errors++; $display("FAIL reset_status got=%b/%b exp=0", o1, o3);
        end
        checks++;
        if ({sig_l, f_l, dev_l} !== 56'd0) begin
            errors++; $display("FAIL reset_latched got=%h exp=0", {sig_l, f_l, dev_l});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_fixed(input string name, input int n, input int p, input int w, input int cycles);
        logic [9:0] e;
        start = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            e = model(c, n, p, w);
            checks++;
            if (o1 !== e) begin
                errors++; $display("FAIL %s c=%0d got=%b exp=%b", name, c, o1, e);
            end
        end
    endtask

    task automatic test_basic();
        t_imp = 10'd2; num = 6'd3; vob = 1'b0; set_entry0(13'd5);
        run_fixed("basic", 3, 5, 2, 18);
        idle_gap();
    endtask

    task automatic test_zero_num();
        num = 6'd0;
        run_fixed("zero_num", 0, 5, 2, 3);
        idle_gap();
    endtask

    task automatic test_clamp();
        t_imp = 10'd10; num = 6'd2; set_entry0(13'd4);
        run_fixed("clamp4", 2, 4, 3, 10);
        idle_gap();
        num = 6'd3; set_entry0(13'd0);
        run_fixed("zero_entry", 3, 1, 0, 5);
        idle_gap();
    endtask

    task automatic test_vobulation();
        int next_start, pulses, actives, dones, done_cyc;
        periods = '0;
        for (int k = 0; k < 32; k++) periods[13*k +: 13] = 13'(3 + k);
        t_imp = 10'd1; num = 6'd34; vob = 1'b1;
        next_start = 1; pulses = 0; actives = 0; dones = 0; done_cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= 610; c++) begin
            @(negedge clk);
            if (pstart) begin
                checks++;
                if (c != next_start || index !== 6'(pulses)) begin
                    errors++;
                    $display("FAIL vob_start got=cycle %0d idx %0d exp=cycle %0d idx %0d",
                             c, index, next_start, pulses);
                end
                next_start += 3 + (pulses % 32);
                pulses++;
            end
            if (active) actives++;
            if (done) begin dones++; done_cyc = c; end
        end
        checks++;
        if (pulses != 34 || actives != 34) begin
            errors++; $display("FAIL vob_counts got=%0d/%0d exp=34/34", pulses, actives);
        end
        checks++;
        if (dones != 1 || done_cyc != 600) begin
            errors++; $display("FAIL vob_done got=%0d@%0d exp=1@600", dones, done_cyc);
        end
        vob = 1'b0;
        idle_gap();
    endtask

    task automatic test_stop();
        logic [9:0] e;
        t_imp = 10'd2; num = 6'd5; set_entry0(13'd5);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            e = (c <= 3) ? model(c, 5, 5, 2) : 10'd0;
            checks++;
            if (o1 !== e) begin
                errors++; $display("FAIL stop_run c=%0d got=%b exp=%b", c, o1, e);
            end
            stop = (c == 3);
        end
        // STOP together with a fresh edge in IDLE: the edge is dropped.
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            stop = 1'b0;
            checks++;
            if (o1 !== 10'd0) begin
                errors++; $display("FAIL stop_wins c=%0d got=%b exp=0", c, o1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        run_fixed("restart", 5, 5, 2, 27);
        idle_gap();
    endtask

    task automatic test_mid_burst_edge();
        logic [9:0] e;
        t_imp = 10'd2; num = 6'd2; set_entry0(13'd5);
        sig_type = 2'b10; f_carrier = 32'hDEAD_BEEF; deviation = 22'h2AAAA;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            e = model(c, 2, 5, 2);
            checks++;
            if (o1 !== e) begin
                errors++; $display("FAIL mid_edge c=%0d got=%b exp=%b", c, o1, e);
            end
            if (c == 6) begin
                checks++;
                if ({sig_l, f_l, dev_l} !== {2'b10, 32'hDEAD_BEEF, 22'h2AAAA}) begin
                    errors++; $display("FAIL latched got=%h exp=%h", {sig_l, f_l, dev_l},
                                       {2'b10, 32'hDEAD_BEEF, 22'h2AAAA});
                end
            end
            if (c == 2) start = 1'b0;
            if (c == 3) begin
                start = 1'b1; num = 6'd5; sig_type = 2'b01;
                f_carrier = 32'h1234_5678; deviation = 22'd0;
            end
        end
        idle_gap();
    endtask

    task automatic test_reset_mid();
        t_imp = 10'd2; num = 6'd3; set_entry0(13'd5); f_carrier = 32'hA5A5_0001;
        run_fixed("pre_reset", 3, 5, 2, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o1 !== 10'd0 || f_l !== 32'd0) begin
            errors++; $display("FAIL async_reset got=%b/%h exp=0/0", o1, f_l);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (o1 !== 10'd0 || o3 !== 10'd0) begin
                errors++; $display("FAIL held_start c=%0d got=%b/%b exp=0", c, o1, o3);
            end
        end
        idle_gap();
    endtask

    task automatic test_prescale();
        logic [9:0] e;
        t_imp = 10'd2; num = 6'd1; set_entry0(13'd5);
        sig_type = 2'b11; f_carrier = 32'h0BAD_F00D; deviation = 22'h155555;
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            e = model(c, 1, 15, 6);
            checks++;
            if (o3 !== e) begin
                errors++; $display("FAIL prescale c=%0d got=%b exp=%b", c, o3, e);
            end
        end
        checks++;
        if ({sig_l3, f_l3, dev_l3} !== {2'b11, 32'h0BAD_F00D, 22'h155555}) begin
            errors++; $display("FAIL prescale_latched got=%h exp=%h", {sig_l3, f_l3, dev_l3},
                               {2'b11, 32'h0BAD_F00D, 22'h155555});
        end
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_num();
        test_clamp();
        test_vobulation();
        test_stop();
        test_mid_burst_edge();
        test_reset_mid();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
